// File: rtl/gsc_pkg.sv
// Shared types and motor command constants for the goal-seek controller.
// GSC_SEARCH_TIMEOUT_EN adds the FAULT state used by the search timeout.
package gsc_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SWEEP   = 3'd1,
      S_ALIGN   = 3'd2,
      S_BACKOFF = 3'd3,
      S_PAUSE   = 3'd4,
      S_DONE    = 3'd5
`ifdef GSC_SEARCH_TIMEOUT_EN
      , S_FAULT = 3'd6
`endif
   } gsc_state_e;

   typedef struct packed {
      logic       fwd_a;
      logic       fwd_b;
      logic       bwd_a;
      logic       bwd_b;
      logic [1:0] duty_a;
      logic [1:0] duty_b;
   } motor_cmd_t;

   // NUDGE is a spin at the higher duty; its direction follows the sweep.
   localparam motor_cmd_t STOP    = motor_cmd_t'({4'b0000, 2'b00, 2'b00});
   localparam motor_cmd_t SPIN_R  = motor_cmd_t'({4'b1001, 2'b01, 2'b01});
   localparam motor_cmd_t SPIN_L  = motor_cmd_t'({4'b0110, 2'b01, 2'b01});
   localparam motor_cmd_t NUDGE_R = motor_cmd_t'({4'b1001, 2'b10, 2'b10});
   localparam motor_cmd_t NUDGE_L = motor_cmd_t'({4'b0110, 2'b10, 2'b10});
   localparam motor_cmd_t REVERSE = motor_cmd_t'({4'b0011, 2'b11, 2'b11});

endpackage

// File: rtl/goal_seek_control_if.sv
// Sensor inputs and motor/status outputs of the goal-seek controller.
interface goal_seek_control_if #(
   parameter int unsigned NUM_BEACONS = 2
);
   localparam int unsigned SEL_W = $clog2(NUM_BEACONS);

   // All signals are levels sampled on the controller clock; there is no
   // valid/ready pairing, Enable is edge-detected inside the controller.
   logic                   Enable;
   logic                   Pause;
   logic                   Inductance;
   logic [NUM_BEACONS-1:0] IR_Hit;
   logic [SEL_W-1:0]       Target_Sel;
   logic                   Start_Dir;

   logic                   FWD_A;
   logic                   FWD_B;
   logic                   BWD_A;
   logic                   BWD_B;
   logic [1:0]             Duty_SelA;
   logic [1:0]             Duty_SelB;
   logic                   Done;
   logic                   Busy;
   logic                   Fault;
   logic [2:0]             State_Out;

   modport master (
      output Enable, Pause, Inductance, IR_Hit, Target_Sel, Start_Dir,
      input  FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB,
      input  Done, Busy, Fault, State_Out
   );

   modport slave (
      input  Enable, Pause, Inductance, IR_Hit, Target_Sel, Start_Dir,
      output FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB,
      output Done, Busy, Fault, State_Out
   );

endinterface

// File: rtl/gsc_timer.sv
// Loadable, holdable down-counter that saturates at zero.
module gsc_timer #(
   parameter int unsigned CNT_W = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = value_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High when the count is, or is about to become, zero.
   assign last_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/goal_seek_control.sv
// Beacon-seeking motor controller: sweep, align on target, back off the wire.
// GSC_SEARCH_TIMEOUT_EN adds a sweep timer that ends a fruitless search in FAULT.
module goal_seek_control
   import gsc_pkg::*;
#(
   parameter int unsigned NUM_BEACONS           = 2,
   parameter int unsigned ALIGN_CYCLES          = 100_000_000,
   parameter int unsigned BACKOFF_CYCLES        = 200_000_000,
   parameter int unsigned SEARCH_TIMEOUT_CYCLES = 1_500_000_000,
   parameter int unsigned CNT_W                 = 31
) (
   input  logic                clk,
   input  logic                Reset_n,
   goal_seek_control_if.slave  bus
);

   localparam int unsigned SEL_W = $clog2(NUM_BEACONS);
   localparam longint unsigned MAX_AB =
      (ALIGN_CYCLES > BACKOFF_CYCLES) ? longint'(ALIGN_CYCLES) : longint'(BACKOFF_CYCLES);
   localparam longint unsigned MAX_CYC =
      (MAX_AB > longint'(SEARCH_TIMEOUT_CYCLES)) ? MAX_AB : longint'(SEARCH_TIMEOUT_CYCLES);

   if ((NUM_BEACONS < 2) || (CNT_W < $clog2(MAX_CYC + 1))) begin : g_param_check
      $error("goal_seek_control: NUM_BEACONS or CNT_W out of range");
   end

   gsc_state_e             state_q, state_d;
   gsc_state_e             saved_q, saved_d;
   logic                   dir_q, dir_d;
   logic [SEL_W-1:0]       tgt_q, tgt_d;
   logic                   en_q;
   logic [NUM_BEACONS-1:0] ir_q;
   motor_cmd_t             motor_q, motor_d;
   logic                   done_q, busy_q;

   logic                   act_load, act_dec, act_last;
   logic [CNT_W-1:0]       act_val;
   logic                   en_rise, tgt_hit, nt_rise;
   logic [NUM_BEACONS-1:0] tgt_mask;

   assign en_rise  = bus.Enable && !en_q;
   assign tgt_mask = {{(NUM_BEACONS-1){1'b0}}, 1'b1} << tgt_q;
   assign tgt_hit  = |(bus.IR_Hit & tgt_mask);
   assign nt_rise  = |(bus.IR_Hit & ~ir_q & ~tgt_mask);
   assign act_dec  = bus.Enable && !bus.Pause &&
                     ((state_q == S_ALIGN) || (state_q == S_BACKOFF));

`ifdef GSC_SEARCH_TIMEOUT_EN
   logic srch_load, srch_dec, srch_last;
   assign srch_dec = bus.Enable && !bus.Pause && (state_q == S_SWEEP);
`endif

   always_comb begin
      state_d  = state_q;
      saved_d  = saved_q;
      dir_d    = dir_q;
      tgt_d    = tgt_q;
      act_load = 1'b0;
      act_val  = '0;
`ifdef GSC_SEARCH_TIMEOUT_EN
      srch_load = 1'b0;
`endif
      if (!bus.Enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_rise) begin
                  state_d = S_SWEEP;
                  tgt_d   = bus.Target_Sel;
                  dir_d   = bus.Start_Dir;
`ifdef GSC_SEARCH_TIMEOUT_EN
                  srch_load = 1'b1;
`endif
               end
            end
            S_SWEEP: begin
               if (bus.Pause) begin
                  state_d = S_PAUSE;
                  saved_d = S_SWEEP;
               end else if (bus.Inductance) begin
                  state_d  = S_BACKOFF;
                  act_load = 1'b1;
                  act_val  = CNT_W'(BACKOFF_CYCLES);
               end else if (tgt_hit) begin
                  state_d  = S_ALIGN;
                  act_load = 1'b1;
                  act_val  = CNT_W'(ALIGN_CYCLES);
`ifdef GSC_SEARCH_TIMEOUT_EN
               end else if (srch_last) begin
                  state_d = S_FAULT;
`endif
               end else if (nt_rise) begin
                  dir_d = ~dir_q;
               end
            end
            S_ALIGN: begin
               if (bus.Pause) begin
                  state_d = S_PAUSE;
                  saved_d = S_ALIGN;
               end else if (bus.Inductance) begin
                  state_d  = S_BACKOFF;
                  act_load = 1'b1;
                  act_val  = CNT_W'(BACKOFF_CYCLES);
               end else if (act_last) begin
                  state_d = S_DONE;
               end
            end
            S_BACKOFF: begin
               if (bus.Pause) begin
                  state_d = S_PAUSE;
                  saved_d = S_BACKOFF;
               end else if (act_last && !bus.Inductance) begin
                  state_d = S_SWEEP;
               end
            end
            S_PAUSE: begin
               if (!bus.Pause) begin
                  state_d = saved_q;
               end
            end
            S_DONE: state_d = S_IDLE;
`ifdef GSC_SEARCH_TIMEOUT_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      motor_d = STOP;
      case (state_q)
         S_SWEEP:   motor_d = dir_q ? SPIN_L : SPIN_R;
         S_ALIGN:   motor_d = dir_q ? NUDGE_L : NUDGE_R;
         S_BACKOFF: motor_d = REVERSE;
         default:   motor_d = STOP;
      endcase
   end

   // Enable history resets high so a level held through reset is not an edge.
   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         saved_q <= S_IDLE;
         dir_q   <= 1'b0;
         tgt_q   <= '0;
         en_q    <= 1'b1;
         ir_q    <= '0;
         motor_q <= STOP;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         dir_q   <= dir_d;
         tgt_q   <= tgt_d;
         en_q    <= bus.Enable;
         ir_q    <= bus.IR_Hit;
         motor_q <= motor_d;
         done_q  <= (state_q == S_DONE);
         busy_q  <= (state_q != S_IDLE);
      end
   end

   gsc_timer #(.CNT_W(CNT_W)) u_act_timer (
      .clk     (clk),
      .rst_n   (Reset_n),
      .clear_i (!bus.Enable),
      .load_i  (act_load),
      .value_i (act_val),
      .dec_i   (act_dec),
      .last_o  (act_last)
   );

`ifdef GSC_SEARCH_TIMEOUT_EN
   logic fault_q;

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state_q == S_FAULT);
      end
   end

   gsc_timer #(.CNT_W(CNT_W)) u_search_timer (
      .clk     (clk),
      .rst_n   (Reset_n),
      .clear_i (!bus.Enable),
      .load_i  (srch_load),
      .value_i (CNT_W'(SEARCH_TIMEOUT_CYCLES)),
      .dec_i   (srch_dec),
      .last_o  (srch_last)
   );

   assign bus.Fault = fault_q;
`else
   assign bus.Fault = 1'b0;
`endif

   assign bus.FWD_A     = motor_q.fwd_a;
   assign bus.FWD_B     = motor_q.fwd_b;
   assign bus.BWD_A     = motor_q.bwd_a;
   assign bus.BWD_B     = motor_q.bwd_b;
   assign bus.Duty_SelA = motor_q.duty_a;
   assign bus.Duty_SelB = motor_q.duty_b;
   assign bus.Done      = done_q;
   assign bus.Busy      = busy_q;
   assign bus.State_Out = state_q;

endmodule

// File: tb/tb_goal_seek_control.sv
// Directed and random stimulus against a cycle model of the goal-seek rules.
module tb_goal_seek_control;

   localparam int NB      = 3;
   localparam int ALIGN   = 8;
   localparam int BACKOFF = 5;
   localparam int SEARCH  = 40;
`ifdef GSC_SEARCH_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   localparam logic [7:0] C_STOP    = 8'b0000_00_00;
   localparam logic [7:0] C_SPIN_R  = 8'b1001_01_01;
   localparam logic [7:0] C_SPIN_L  = 8'b0110_01_01;
   localparam logic [7:0] C_NUDGE_R = 8'b1001_10_10;
   localparam logic [7:0] C_NUDGE_L = 8'b0110_10_10;
   localparam logic [7:0] C_REV     = 8'b0011_11_11;

   typedef enum int {
      M_IDLE = 0, M_SWEEP = 1, M_ALIGN = 2, M_BACKOFF = 3,
      M_PAUSE = 4, M_DONE = 5, M_FAULT = 6
   } m_state_e;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   goal_seek_control_if #(.NUM_BEACONS(NB)) bus ();

   goal_seek_control #(
      .NUM_BEACONS           (NB),
      .ALIGN_CYCLES          (ALIGN),
      .BACKOFF_CYCLES        (BACKOFF),
      .SEARCH_TIMEOUT_CYCLES (SEARCH),
      .CNT_W                 (31)
   ) dut (
      .clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   m_state_e  m_st, m_saved;
   int        m_left, m_srch, m_tgt;
   logic      m_dir, m_prev_en;
   logic [NB-1:0] m_prev_ir;

   logic [7:0] obs_cmd;
   logic       obs_done, obs_fault;
   logic [2:0] obs_state;

   function automatic logic [7:0] exp_cmd(input m_state_e st, input logic dir);
      case (st)
         M_SWEEP:   return dir ? C_SPIN_L : C_SPIN_R;
         M_ALIGN:   return dir ? C_NUDGE_L : C_NUDGE_R;
         M_BACKOFF: return C_REV;
         default:   return C_STOP;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model on the inputs seen at the edge, then check.
   task automatic tick();
      m_state_e      nx;
      logic [7:0]    e_cmd;
      logic          e_done, e_busy, e_fault;
      logic [NB-1:0] nt;
      @(posedge clk);
      if (!rst_n) begin
         e_cmd = C_STOP; e_done = 1'b0; e_busy = 1'b0; e_fault = 1'b0;
         m_st = M_IDLE; m_saved = M_IDLE; m_left = 0; m_srch = 0;
         m_dir = 1'b0; m_tgt = 0; m_prev_en = 1'b1; m_prev_ir = '0;
      end else begin
         e_cmd   = exp_cmd(m_st, m_dir);
         e_done  = (m_st == M_DONE);
         e_busy  = (m_st != M_IDLE);
         e_fault = (m_st == M_FAULT);
         nt = bus.IR_Hit & ~m_prev_ir;
         nt[m_tgt] = 1'b0;
         nx = m_st;
         if (!bus.Enable) begin
            nx = M_IDLE; m_left = 0; m_srch = 0;
         end else begin
            case (m_st)
               M_IDLE: if (!m_prev_en) begin
                  nx = M_SWEEP; m_tgt = int'(bus.Target_Sel);
                  m_dir = bus.Start_Dir; m_srch = SEARCH;
               end
               M_SWEEP: if (bus.Pause) begin
                  nx = M_PAUSE; m_saved = M_SWEEP;
               end else begin
                  if (m_srch > 0) m_srch--;
                  if (bus.Inductance) begin
                     nx = M_BACKOFF; m_left = BACKOFF;
                  end else if (bus.IR_Hit[m_tgt]) begin
                     nx = M_ALIGN; m_left = ALIGN;
                  end else if (TIMEOUT_EN && m_srch == 0) begin
                     nx = M_FAULT;
                  end else if (nt != '0) begin
                     m_dir = ~m_dir;
                  end
               end
               M_ALIGN: if (bus.Pause) begin
                  nx = M_PAUSE; m_saved = M_ALIGN;
               end else if (bus.Inductance) begin
                  nx = M_BACKOFF; m_left = BACKOFF;
               end else begin
                  if (m_left > 0) m_left--;
                  if (m_left == 0) nx = M_DONE;
               end
               M_BACKOFF: if (bus.Pause) begin
                  nx = M_PAUSE; m_saved = M_BACKOFF;
               end else begin
                  if (m_left > 0) m_left--;
                  if (m_left == 0 && !bus.Inductance) nx = M_SWEEP;
               end
               M_PAUSE: if (!bus.Pause) nx = m_saved;
               M_DONE:  nx = M_IDLE;
               default: nx = m_st;
            endcase
         end
         m_st      = nx;
         m_prev_en = bus.Enable;
         m_prev_ir = bus.IR_Hit;
      end
      #1;
      obs_cmd   = {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B, bus.Duty_SelA, bus.Duty_SelB};
      obs_done  = bus.Done;
      obs_fault = bus.Fault;
      obs_state = bus.State_Out;
      chk("state", 32'(obs_state), 32'(m_st));
      chk("motor", 32'(obs_cmd), 32'(e_cmd));
      chk("done",  32'(obs_done), 32'(e_done));
      chk("busy",  32'(bus.Busy), 32'(e_busy));
      chk("fault", 32'(obs_fault), 32'(e_fault));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n_a, n_b, n_c;
      rst_n = 1'b0;
      bus.Enable = 1'b0; bus.Pause = 1'b0; bus.Inductance = 1'b0;
      bus.IR_Hit = '0; bus.Target_Sel = 2'd2; bus.Start_Dir = 1'b0;
      m_st = M_IDLE; m_saved = M_IDLE; m_left = 0; m_srch = 0;
      m_dir = 1'b0; m_tgt = 0; m_prev_en = 1'b1; m_prev_ir = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Target hit after ten sweep cycles, align ignores IR changes.
      bus.Enable = 1'b1; bus.Target_Sel = 2'd2; bus.Start_Dir = 1'b0;
      tick();
      repeat (9) tick();
      bus.IR_Hit = 3'b100;
      tick();
      n_a = 0; n_b = 0;
      for (int i = 0; i < 14; i++) begin
         bus.IR_Hit = 3'($urandom_range(0, 7));
         tick();
         if (obs_cmd == C_NUDGE_R) n_a++;
         if (obs_done) n_b++;
      end
      chk("align_len", 32'(n_a), 32'(ALIGN));
      chk("done_width", 32'(n_b), 32'd1);
      chk("idle_after_done", 32'(obs_state), 32'd0);

      // Non-target rising edges toggle the sweep once per edge.
      bus.Enable = 1'b0; bus.IR_Hit = '0;
      tick();
      bus.Enable = 1'b1;
      tick();
      repeat (2) tick();
      bus.IR_Hit = 3'b001;
      repeat (6) tick();
      chk("toggle_once", 32'(obs_cmd), 32'(C_SPIN_L));
      bus.IR_Hit = 3'b000;
      repeat (2) tick();
      bus.IR_Hit = 3'b001;
      repeat (2) tick();
      chk("toggle_back", 32'(obs_cmd), 32'(C_SPIN_R));

      // Short inductance pulse during align.
      bus.IR_Hit = 3'b100;
      tick();
      bus.IR_Hit = 3'b000;
      repeat (2) tick();
      n_a = 0;
      for (int i = 0; i < 12; i++) begin
         bus.Inductance = (i < 2);
         tick();
         if (obs_cmd == C_REV) n_a++;
      end
      chk("backoff_short", 32'(n_a), 32'(BACKOFF));

      // Held inductance extends the backoff.
      bus.IR_Hit = 3'b100;
      tick();
      bus.IR_Hit = 3'b000;
      tick();
      n_a = 0;
      for (int i = 0; i < 16; i++) begin
         bus.Inductance = (i < 9);
         tick();
         if (obs_cmd == C_REV) n_a++;
      end
      chk("backoff_held", 32'(n_a), 32'd9);
      chk("sweep_after_backoff", 32'(obs_state), 32'd1);

      // Pause at align count 3.
      bus.Enable = 1'b0;
      tick();
      bus.Enable = 1'b1;
      tick();
      bus.IR_Hit = 3'b100;
      tick();
      bus.IR_Hit = 3'b000;
      repeat (ALIGN - 3) tick();
      bus.Pause = 1'b1;
      n_a = 0;
      repeat (20) begin
         tick();
         if (obs_cmd == C_STOP) n_a++;
      end
      bus.Pause = 1'b0;
      tick();
      if (obs_cmd == C_STOP) n_a++;
      chk("pause_stop", 32'(n_a), 32'd20);
      n_b = 0; n_c = 0;
      repeat (7) begin
         tick();
         if (obs_cmd == C_NUDGE_R) n_b++;
         if (obs_done) n_c++;
      end
      chk("resume_nudge", 32'(n_b), 32'd3);
      chk("resume_done", 32'(n_c), 32'd1);

      // Random traffic, including resets and enable drops.
      for (int i = 0; i < 500; i++) begin
         rst_n          = ($urandom_range(0, 99) != 0);
         bus.Enable     = ($urandom_range(0, 39) != 0);
         bus.Pause      = ($urandom_range(0, 14) == 0);
         bus.Inductance = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 5) == 0) bus.IR_Hit = 3'($urandom_range(0, 7));
         bus.Target_Sel = 2'($urandom_range(0, 2));
         bus.Start_Dir  = 1'($urandom_range(0, 1));
         tick();
      end
      rst_n = 1'b1; bus.Pause = 1'b0; bus.Inductance = 1'b0; bus.IR_Hit = '0;

      // Fruitless search: FAULT only when the timeout is built in.
      bus.Enable = 1'b0;
      tick();
      bus.Enable = 1'b1; bus.Target_Sel = 2'd1;
      tick();
      repeat (45) tick();
      chk("fault_set", 32'(obs_fault), 32'(TIMEOUT_EN));
      bus.Enable = 1'b0;
      repeat (2) tick();
      chk("fault_clear", 32'(obs_fault), 32'd0);

      // Reset in BACKOFF with Enable held high through release.
      bus.Enable = 1'b1; bus.Target_Sel = 2'd2;
      tick();
      bus.IR_Hit = 3'b100;
      tick();
      bus.IR_Hit = 3'b000; bus.Inductance = 1'b1;
      tick();
      bus.Inductance = 1'b0;
      tick();
      chk("in_backoff", 32'(obs_state), 32'd3);
      rst_n = 1'b0;
      tick();
      chk("reset_idle", 32'(obs_state), 32'd0);
      chk("reset_stop", 32'(obs_cmd), 32'(C_STOP));
      rst_n = 1'b1;
      repeat (5) tick();
      chk("no_restart", 32'(obs_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
